// File: rtl/stage_memory_pkg.sv
//------------------------------------------------------------------------------
// Module   : stage_memory_pkg
// Brief    : Shared opcode / ALU-op / state definitions for the memory stage
//            and the writeback-stage decoders that follow it.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package stage_memory_pkg;

  // Instruction opcodes carried through the pipeline latches.
  typedef enum logic [4:0] {
    c_OP_R    = 5'b00000,
    c_OP_JAL  = 5'b00011,
    c_OP_ADDI = 5'b00101,
    c_OP_SW   = 5'b00111,
    c_OP_LW   = 5'b01000
  } opcode_t;

  // ALU operation codes carried alongside the opcode.
  typedef enum logic [4:0] {
    c_ALU_ADD = 5'd0,
    c_ALU_SUB = 5'd1,
    c_ALU_MUL = 5'd2,
    c_ALU_DIV = 5'd3
  } alu_op_t;

  // Data-memory handshake states.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } hs_state_t;

  // M/W latch contents; all-zero is a bubble (add into r0, no exception).
  typedef struct packed {
    logic [4:0]  opcode;
    logic [4:0]  alu_op;
    logic [4:0]  rd;
    logic [31:0] o;
    logic [31:0] pc_plus_4;
    logic [4:0]  pc_upper_5;
    logic [26:0] target;
    logic [31:0] d;
    logic        exception;
  } mw_latch_t;

  // True when a valid instruction needs the data memory.
  function automatic logic is_mem_op(input logic valid, input logic [4:0] opcode);
    return valid & ((opcode == c_OP_LW) | (opcode == c_OP_SW));
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_handshake.sv
//------------------------------------------------------------------------------
// Module   : dmem_handshake
// Brief    : req/ack data-memory handshake FSM with timeout counter, request
//            registers, upstream stall and sticky bus_error.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmem_handshake
  import stage_memory_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_mem_op,
  input  logic              i_is_store,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_data,
  input  logic              i_ack,
  output logic              o_stall,
  output logic              o_idle,
  output logic              o_done,
  output logic              o_req,
  output logic              o_wren,
  output logic [ADDR_W-1:0] o_addr,
  output logic [31:0]       o_data,
  output logic              o_bus_error
);

  // Last count value in WAIT before the access is abandoned.
  localparam logic [7:0] c_LAST = 8'(TIMEOUT - 1);

  hs_state_t         r_state;
  logic [7:0]        r_count;
  logic              r_req;
  logic              r_wren;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic              r_bus_error;

  logic w_in_wait;
  logic w_last;

  assign w_in_wait = (r_state == ST_WAIT);
  assign w_last    = (r_count == c_LAST);

  // Hold upstream while a request is being issued or still outstanding.
  always_comb begin
    o_stall = 1'b0;
    case (r_state)
      ST_IDLE: o_stall = i_mem_op;
      ST_WAIT: o_stall = ~i_ack & ~w_last;
      default: o_stall = 1'b0;
    endcase
  end

  // Handshake FSM: issue request, count wait cycles, finish on ack or timeout.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_req       <= 1'b0;
      r_wren      <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_bus_error <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_mem_op) begin
            r_state <= ST_WAIT;
            r_count <= '0;
            r_req   <= 1'b1;
            r_wren  <= i_is_store;
            r_addr  <= i_addr;
            r_data  <= i_data;
          end
        end
        ST_WAIT: begin
          if (i_ack) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_wren  <= 1'b0;
          end else if (w_last) begin
            // Abort: result is dropped and the store is not retried.
            r_state     <= ST_IDLE;
            r_req       <= 1'b0;
            r_wren      <= 1'b0;
            r_bus_error <= 1'b1;
          end else begin
            r_count <= r_count + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_idle      = ~w_in_wait;
  assign o_done      = w_in_wait & i_ack;
  assign o_req       = r_req;
  assign o_wren      = r_wren;
  assign o_addr      = r_addr;
  assign o_data      = r_data;
  assign o_bus_error = r_bus_error;

endmodule

`default_nettype wire

// File: rtl/stage_memory.sv
//------------------------------------------------------------------------------
// Module   : stage_memory
// Brief    : Pipeline memory stage: lw/sw via dmem handshake, upstream stall,
//            and the M/W latch that feeds writeback.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module stage_memory
  import stage_memory_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [4:0]        in_opcode,
  input  logic [4:0]        in_ALU_op,
  input  logic [4:0]        in_rd,
  input  logic [31:0]       in_o,
  input  logic [31:0]       in_b,
  input  logic [31:0]       in_pc_plus_4,
  input  logic [4:0]        in_pc_upper_5,
  input  logic [26:0]       in_target,
  input  logic              in_exception,
  output logic              stall,
  output logic              req_dmem,
  output logic              wren_dmem,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [31:0]       data_dmem,
  input  logic              ack_dmem,
  input  logic [31:0]       q_dmem,
  output logic [4:0]        out_opcode,
  output logic [4:0]        out_ALU_op,
  output logic [4:0]        out_rd,
  output logic [31:0]       out_o,
  output logic [31:0]       out_pc_plus_4,
  output logic [4:0]        out_pc_upper_5,
  output logic [26:0]       out_target,
  output logic [31:0]       out_d,
  output logic              out_exception,
  output logic              bus_error
);

  logic      w_mem_op;
  logic      w_is_store;
  logic      w_is_load;
  logic      w_idle;
  logic      w_done;
  logic      w_load_instr;
  logic [31:0] w_load_d;
  mw_latch_t r_mw;

  assign w_mem_op   = is_mem_op(in_valid, in_opcode);
  assign w_is_store = (in_opcode == c_OP_SW);
  assign w_is_load  = (in_opcode == c_OP_LW);

  dmem_handshake #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) u_dmem_handshake (
    .clock       (clock),
    .reset       (reset),
    .i_mem_op    (w_mem_op),
    .i_is_store  (w_is_store),
    .i_addr      (in_o[ADDR_W-1:0]),
    .i_data      (in_b),
    .i_ack       (ack_dmem),
    .o_stall     (stall),
    .o_idle      (w_idle),
    .o_done      (w_done),
    .o_req       (req_dmem),
    .o_wren      (wren_dmem),
    .o_addr      (address_dmem),
    .o_data      (data_dmem),
    .o_bus_error (bus_error)
  );

  // A real instruction retires either straight through or on its memory ack.
  assign w_load_instr = (w_idle & in_valid & ~w_mem_op) | w_done;
  assign w_load_d     = (w_done & w_is_load) ? q_dmem : 32'd0;

  // M/W latch: retiring instruction, otherwise a bubble.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mw <= '0;
    end else if (w_load_instr) begin
      r_mw.opcode     <= in_opcode;
      r_mw.alu_op     <= in_ALU_op;
      r_mw.rd         <= in_rd;
      r_mw.o          <= in_o;
      r_mw.pc_plus_4  <= in_pc_plus_4;
      r_mw.pc_upper_5 <= in_pc_upper_5;
      r_mw.target     <= in_target;
      r_mw.d          <= w_load_d;
      r_mw.exception  <= in_exception;
    end else begin
      r_mw <= '0;
    end
  end

  assign out_opcode     = r_mw.opcode;
  assign out_ALU_op     = r_mw.alu_op;
  assign out_rd         = r_mw.rd;
  assign out_o          = r_mw.o;
  assign out_pc_plus_4  = r_mw.pc_plus_4;
  assign out_pc_upper_5 = r_mw.pc_upper_5;
  assign out_target     = r_mw.target;
  assign out_d          = r_mw.d;
  assign out_exception  = r_mw.exception;

endmodule

`default_nettype wire

// File: tb/tb_stage_memory.sv
//------------------------------------------------------------------------------
// Module   : tb_stage_memory
// Brief    : Self-checking bench for stage_memory with a cycle-level reference
//            model, directed scenarios and a randomized memory responder.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_stage_memory;
  import stage_memory_pkg::*;

  localparam int ADDR_W  = 12;
  localparam int TIMEOUT = 15;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic [4:0]        in_opcode = '0, in_ALU_op = '0, in_rd = '0;
  logic [31:0]       in_o = '0, in_b = '0, in_pc_plus_4 = '0;
  logic [4:0]        in_pc_upper_5 = '0;
  logic [26:0]       in_target = '0;
  logic              in_exception = 1'b0;
  logic              ack_dmem = 1'b0;
  logic [31:0]       q_dmem = '0;
  logic              stall, req_dmem, wren_dmem, bus_error, out_exception;
  logic [ADDR_W-1:0] address_dmem;
  logic [31:0]       data_dmem, out_o, out_pc_plus_4, out_d;
  logic [4:0]        out_opcode, out_ALU_op, out_rd, out_pc_upper_5;
  logic [26:0]       out_target;

  stage_memory #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_opcode(in_opcode),
    .in_ALU_op(in_ALU_op), .in_rd(in_rd), .in_o(in_o), .in_b(in_b),
    .in_pc_plus_4(in_pc_plus_4), .in_pc_upper_5(in_pc_upper_5),
    .in_target(in_target), .in_exception(in_exception), .stall(stall),
    .req_dmem(req_dmem), .wren_dmem(wren_dmem), .address_dmem(address_dmem),
    .data_dmem(data_dmem), .ack_dmem(ack_dmem), .q_dmem(q_dmem),
    .out_opcode(out_opcode), .out_ALU_op(out_ALU_op), .out_rd(out_rd),
    .out_o(out_o), .out_pc_plus_4(out_pc_plus_4), .out_pc_upper_5(out_pc_upper_5),
    .out_target(out_target), .out_d(out_d), .out_exception(out_exception),
    .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        valid;
    logic [4:0]  opcode, alu_op, rd;
    logic [31:0] o, b, pc4;
    logic [4:0]  pcu;
    logic [26:0] tgt;
    logic        exc;
  } instr_t;

  // Reference model state: what the stage must look like right now.
  bit                m_busy;
  int                m_waited;
  logic              m_req, m_wren, m_berr;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_data;
  mw_latch_t         m_mw;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [143:0] dut_mw();
    return {out_opcode, out_ALU_op, out_rd, out_o, out_pc_plus_4, out_pc_upper_5,
            out_target, out_d, out_exception};
  endfunction

  function automatic mw_latch_t to_mw(input instr_t i, input logic [31:0] d);
    mw_latch_t r;
    r.opcode = i.opcode; r.alu_op = i.alu_op; r.rd = i.rd; r.o = i.o;
    r.pc_plus_4 = i.pc4; r.pc_upper_5 = i.pcu; r.target = i.tgt;
    r.d = d; r.exception = i.exc;
    return r;
  endfunction

  function automatic instr_t mk(input logic [4:0] op, input logic [4:0] rd,
                                input logic [31:0] o, input logic [31:0] b);
    instr_t r;
    r.valid = 1'b1; r.opcode = op; r.alu_op = c_ALU_ADD; r.rd = rd; r.o = o; r.b = b;
    r.pc4 = 32'h0000_1004; r.pcu = 5'd0; r.tgt = 27'h123; r.exc = 1'b0;
    return r;
  endfunction

  function automatic instr_t rand_instr();
    instr_t r;
    r.valid = ($urandom_range(0, 5) != 0);
    case ($urandom_range(0, 4))
      0: r.opcode = c_OP_LW;
      1: r.opcode = c_OP_SW;
      2: r.opcode = c_OP_R;
      3: r.opcode = c_OP_ADDI;
      default: r.opcode = c_OP_JAL;
    endcase
    r.alu_op = 5'($urandom); r.rd = 5'($urandom); r.o = $urandom; r.b = $urandom;
    r.pc4 = $urandom; r.pcu = 5'($urandom); r.tgt = 27'($urandom);
    r.exc = 1'($urandom);
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_waited = 0; m_req = 0; m_wren = 0; m_berr = 0;
    m_addr = '0; m_data = '0; m_mw = '0;
  endtask

  task automatic chk_regs();
    chk("req_dmem", 144'(req_dmem), 144'(m_req));
    chk("wren_dmem", 144'(wren_dmem), 144'(m_wren));
    chk("bus_error", 144'(bus_error), 144'(m_berr));
    chk("mw_latch", dut_mw(), m_mw);
    if (m_req) begin
      chk("address_dmem", 144'(address_dmem), 144'(m_addr));
      chk("data_dmem", 144'(data_dmem), 144'(m_data));
    end
  endtask

  // One clock cycle: drive, check against model, advance model at the edge.
  task automatic step(input instr_t ins, input logic ack, input logic [31:0] q,
                      output logic consumed);
    logic mem, exp_stall;
    mw_latch_t nmw;
    @(negedge clock);
    in_valid = ins.valid; in_opcode = ins.opcode; in_ALU_op = ins.alu_op;
    in_rd = ins.rd; in_o = ins.o; in_b = ins.b; in_pc_plus_4 = ins.pc4;
    in_pc_upper_5 = ins.pcu; in_target = ins.tgt; in_exception = ins.exc;
    ack_dmem = ack; q_dmem = q;
    #1;
    mem = ins.valid && (ins.opcode == c_OP_LW || ins.opcode == c_OP_SW);
    if (!m_busy)                       exp_stall = mem;
    else if (ack)                      exp_stall = 1'b0;
    else if (m_waited == TIMEOUT - 1)  exp_stall = 1'b0;
    else                               exp_stall = 1'b1;
    chk("stall", 144'(stall), 144'(exp_stall));
    chk_regs();
    @(posedge clock);
    nmw = '0;
    if (!m_busy) begin
      if (mem) begin
        m_busy = 1; m_waited = 0; m_req = 1'b1;
        m_wren = (ins.opcode == c_OP_SW); m_addr = ins.o[ADDR_W-1:0]; m_data = ins.b;
      end else if (ins.valid) begin
        nmw = to_mw(ins, 32'd0);
      end
    end else if (ack) begin
      nmw = to_mw(ins, (ins.opcode == c_OP_LW) ? q : 32'd0);
      m_busy = 0; m_req = 1'b0; m_wren = 1'b0;
    end else if (m_waited == TIMEOUT - 1) begin
      m_busy = 0; m_req = 1'b0; m_wren = 1'b0; m_berr = 1'b1;
    end else begin
      m_waited++;
    end
    m_mw = nmw;
    consumed = ins.valid && !exp_stall;
    #1;
  endtask

  initial begin
    instr_t cur, bub;
    logic   cons, ack;
    logic [31:0] q;
    int     n, lat, wc;

    model_reset();
    bub = mk(5'd0, 5'd0, 32'd0, 32'd0);
    bub.valid = 1'b0;

    // Reset state.
    @(negedge clock); #1;
    chk("reset_mw", dut_mw(), 144'd0);
    chk("reset_req", 144'(req_dmem), 144'd0);
    chk("reset_bus_error", 144'(bus_error), 144'd0);
    @(negedge clock);
    reset = 1'b1;

    // Plain add passes through in one cycle.
    step(mk(c_OP_R, 5'd3, 32'h7, 32'h0), 1'b0, 32'h0, cons);
    chk("add_out_o", 144'(out_o), 144'd7);
    chk("add_out_rd", 144'(out_rd), 144'd3);

    // lw with ack on the third WAIT cycle.
    step(mk(c_OP_LW, 5'd4, 32'h40, 32'h0), 1'b0, 32'h0, cons);
    chk("lw_req", 144'(req_dmem), 144'd1);
    chk("lw_addr", 144'(address_dmem), 144'h040);
    chk("lw_wren", 144'(wren_dmem), 144'd0);
    step(mk(c_OP_LW, 5'd4, 32'h40, 32'h0), 1'b0, 32'h0, cons);
    step(mk(c_OP_LW, 5'd4, 32'h40, 32'h0), 1'b0, 32'h0, cons);
    step(mk(c_OP_LW, 5'd4, 32'h40, 32'h0), 1'b1, 32'hDEADBEEF, cons);
    chk("lw_out_d", 144'(out_d), 144'hDEADBEEF);
    chk("lw_out_opcode", 144'(out_opcode), 144'(5'b01000));

    // sw: write request, latch shows the sw with d=0.
    step(mk(c_OP_SW, 5'd0, 32'h10, 32'h1234), 1'b0, 32'h0, cons);
    chk("sw_wren", 144'(wren_dmem), 144'd1);
    chk("sw_addr", 144'(address_dmem), 144'h010);
    chk("sw_data", 144'(data_dmem), 144'h1234);
    step(mk(c_OP_SW, 5'd0, 32'h10, 32'h1234), 1'b1, 32'h5555_AAAA, cons);
    chk("sw_out_d", 144'(out_d), 144'd0);
    chk("sw_out_opcode", 144'(out_opcode), 144'(5'b00111));

    // lw with no ack: timeout after TIMEOUT WAIT cycles.
    n = 0;
    do begin
      step(mk(c_OP_LW, 5'd5, 32'h80, 32'h0), 1'b0, 32'h0, cons);
      n++;
    end while (!cons && n < 40);
    chk("timeout_cycles", 144'(n), 144'(1 + TIMEOUT));
    chk("timeout_bus_error", 144'(bus_error), 144'd1);
    chk("timeout_bubble", dut_mw(), 144'd0);
    step(mk(c_OP_R, 5'd6, 32'h99, 32'h0), 1'b0, 32'h0, cons);
    chk("after_timeout_add", 144'(out_o), 144'h99);
    chk("sticky_bus_error", 144'(bus_error), 144'd1);

    // Reset pulsed during WAIT.
    step(mk(c_OP_LW, 5'd7, 32'h44, 32'h0), 1'b0, 32'h0, cons);
    step(mk(c_OP_LW, 5'd7, 32'h44, 32'h0), 1'b0, 32'h0, cons);
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_req_drop", 144'(req_dmem), 144'd0);
    chk("rst_mw_clear", dut_mw(), 144'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    step(bub, 1'b1, 32'hCAFE_F00D, cons);
    chk("late_ack_d", 144'(out_d), 144'd0);
    chk("late_ack_req", 144'(req_dmem), 144'd0);

    // Randomized traffic with a random-latency responder.
    cur = rand_instr();
    lat = 1; wc = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      ack = 1'b0;
      q   = $urandom;
      if (m_busy) begin
        wc++;
        if (wc == lat) ack = 1'b1;
      end else begin
        wc  = 0;
        lat = ($urandom_range(0, 9) == 0) ? 99 : $urandom_range(1, 4);
        if ($urandom_range(0, 7) == 0) ack = 1'b1;
      end
      step(cur, ack, q, cons);
      if (cons) cur = rand_instr();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
